// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use and branch-in-ID data hazards,
// data-memory freeze, MUL/DIV occupancy tracking and a saturating stall counter.
module hazard_stall_ctrl #(
    parameter int unsigned REG_W        = 5,
    parameter int unsigned MULDIV_LAT   = 4,
    parameter int unsigned BRANCH_IN_ID = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [REG_W-1:0] IF_ID_Rs,
    input  logic [REG_W-1:0] IF_ID_Rt,
    input  logic             IF_ID_UsesRt,
    input  logic             IF_ID_Branch,
    input  logic             IF_ID_MulDiv,
    input  logic             IF_ID_ReadsHiLo,
    input  logic             ID_EX_RegWrite,
    input  logic             ID_EX_MemRead,
    input  logic [REG_W-1:0] ID_EX_WrReg,
    input  logic             EX_MEM_RegWrite,
    input  logic             EX_MEM_MemRead,
    input  logic [REG_W-1:0] EX_MEM_WrReg,
    input  logic             Mem_Ready,
    output logic             PC_en,
    output logic             IF_ID_en,
    output logic             Ctrl_Mux,
    output logic             Pipe_freeze,
    output logic             MulDiv_Busy,
    output logic [CNT_W-1:0] Stall_Count
);

    localparam int unsigned CW = $clog2(MULDIV_LAT);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_branch_id;
    logic w_freeze;
    logic w_h_lu;
    logic w_h_bex;
    logic w_h_bmem;
    logic w_h_md;
    logic w_hazard;
    logic w_busy_st;
    logic w_issue;

    // A producer register matches if it is non-zero and read by the ID instruction.
    function automatic logic f_match(input logic [REG_W-1:0] r,
                                     input logic [REG_W-1:0] rs,
                                     input logic [REG_W-1:0] rt,
                                     input logic             uses_rt);
        return (r != '0) && ((r == rs) || (uses_rt && (r == rt)));
    endfunction

    always_comb begin
        w_branch_id = (BRANCH_IN_ID != 0) && IF_ID_Branch;
        w_busy_st   = (r_state == S_BUSY);
        w_freeze    = EX_MEM_MemRead && !Mem_Ready;
        w_h_lu      = ID_EX_RegWrite && ID_EX_MemRead
                      && f_match(ID_EX_WrReg, IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt);
        w_h_bex     = w_branch_id && ID_EX_RegWrite
                      && f_match(ID_EX_WrReg, IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt);
        w_h_bmem    = w_branch_id && EX_MEM_RegWrite && EX_MEM_MemRead
                      && f_match(EX_MEM_WrReg, IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt);
        w_h_md      = w_busy_st && (IF_ID_MulDiv || IF_ID_ReadsHiLo);
        w_hazard    = w_h_lu || w_h_bex || w_h_bmem || w_h_md;
        w_issue     = IF_ID_MulDiv && !Rst && !w_freeze && !w_hazard;
    end

    // Output priority: reset, then freeze (hold without bubble), then hazard bubble.
    always_comb begin
        PC_en       = 1'b1;
        IF_ID_en    = 1'b1;
        Ctrl_Mux    = 1'b1;
        Pipe_freeze = 1'b0;
        MulDiv_Busy = w_busy_st && !Rst;
        if (Rst) begin
            PC_en = 1'b1;
        end else if (w_freeze) begin
            PC_en       = 1'b0;
            IF_ID_en    = 1'b0;
            Pipe_freeze = 1'b1;
        end else if (w_hazard) begin
            PC_en    = 1'b0;
            IF_ID_en = 1'b0;
            Ctrl_Mux = 1'b0;
        end
    end

    assign Stall_Count = r_stall_cnt;

    // MUL/DIV busy FSM; the countdown holds while the pipeline is frozen.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (!IF_ID_en && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_state <= S_BUSY;
                        r_cnt   <= CW'(MULDIV_LAT - 1);
                    end
                end
                S_BUSY: begin
                    if (!w_freeze) begin
                        if (r_cnt == CW'(1)) begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: vector table, hand-built multi-cycle sequences
// and random stimulus against a cycle-level reference model.
module tb_hazard_stall_ctrl;

    localparam int unsigned LAT = 4;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       br;
        logic       md;
        logic       hilo;
        logic       ex_rw;
        logic       ex_mr;
        logic [4:0] ex_wr;
        logic       mem_rw;
        logic       mem_mr;
        logic [4:0] mem_wr;
        logic       mem_rdy;
    } in_t;

    typedef struct {
        string      nm;
        in_t        in;
        logic [3:0] ea;
        logic [3:0] eb;
    } vec_t;

    logic Clk = 1'b0;
    logic rst;
    in_t  cur;

    logic        a_pc, a_ifid, a_ctrl, a_frz, a_busy;
    logic [15:0] a_cnt;
    logic        b_pc, b_ifid, b_ctrl, b_frz, b_busy;
    logic [1:0]  b_cnt;

    int n_checks = 0;
    int n_err    = 0;
    int busy_left [2];
    int scnt      [2];
    int cmax      [2];
    bit bid       [2];
    vec_t vecs[$];

    always #5 Clk = ~Clk;

    hazard_stall_ctrl #(.REG_W(5), .MULDIV_LAT(LAT), .BRANCH_IN_ID(1), .CNT_W(16)) u_a (
        .Clk(Clk), .Rst(rst),
        .IF_ID_Rs(cur.rs), .IF_ID_Rt(cur.rt), .IF_ID_UsesRt(cur.uses_rt),
        .IF_ID_Branch(cur.br), .IF_ID_MulDiv(cur.md), .IF_ID_ReadsHiLo(cur.hilo),
        .ID_EX_RegWrite(cur.ex_rw), .ID_EX_MemRead(cur.ex_mr), .ID_EX_WrReg(cur.ex_wr),
        .EX_MEM_RegWrite(cur.mem_rw), .EX_MEM_MemRead(cur.mem_mr), .EX_MEM_WrReg(cur.mem_wr),
        .Mem_Ready(cur.mem_rdy),
        .PC_en(a_pc), .IF_ID_en(a_ifid), .Ctrl_Mux(a_ctrl), .Pipe_freeze(a_frz),
        .MulDiv_Busy(a_busy), .Stall_Count(a_cnt)
    );

    hazard_stall_ctrl #(.REG_W(5), .MULDIV_LAT(LAT), .BRANCH_IN_ID(0), .CNT_W(2)) u_b (
        .Clk(Clk), .Rst(rst),
        .IF_ID_Rs(cur.rs), .IF_ID_Rt(cur.rt), .IF_ID_UsesRt(cur.uses_rt),
        .IF_ID_Branch(cur.br), .IF_ID_MulDiv(cur.md), .IF_ID_ReadsHiLo(cur.hilo),
        .ID_EX_RegWrite(cur.ex_rw), .ID_EX_MemRead(cur.ex_mr), .ID_EX_WrReg(cur.ex_wr),
        .EX_MEM_RegWrite(cur.mem_rw), .EX_MEM_MemRead(cur.mem_mr), .EX_MEM_WrReg(cur.mem_wr),
        .Mem_Ready(cur.mem_rdy),
        .PC_en(b_pc), .IF_ID_en(b_ifid), .Ctrl_Mux(b_ctrl), .Pipe_freeze(b_frz),
        .MulDiv_Busy(b_busy), .Stall_Count(b_cnt)
    );

    function automatic in_t mk(input int rs, input int rt, input bit ur, input bit br,
                               input bit md, input bit hl, input bit exrw, input bit exmr,
                               input int exwr, input bit mrw, input bit mmr, input int mwr,
                               input bit rdy);
        in_t x;
        x.rs = 5'(rs); x.rt = 5'(rt); x.uses_rt = ur; x.br = br; x.md = md; x.hilo = hl;
        x.ex_rw = exrw; x.ex_mr = exmr; x.ex_wr = 5'(exwr);
        x.mem_rw = mrw; x.mem_mr = mmr; x.mem_wr = 5'(mwr); x.mem_rdy = rdy;
        return x;
    endfunction

    function automatic bit hit(input in_t x, input logic [4:0] r);
        return (r != 0) && (r == x.rs || (x.uses_rt && r == x.rt));
    endfunction

    // Expected {PC_en, IF_ID_en, Ctrl_Mux, Pipe_freeze} from the priority rules.
    function automatic logic [3:0] model_out(input in_t x, input bit r, input bit busy,
                                             input bit b_id);
        bit lu, bex, bmem, mdh;
        if (r) return 4'b1110;
        if (x.mem_mr && !x.mem_rdy) return 4'b0011;
        lu   = x.ex_rw && x.ex_mr && hit(x, x.ex_wr);
        bex  = b_id && x.br && x.ex_rw && hit(x, x.ex_wr);
        bmem = b_id && x.br && x.mem_rw && x.mem_mr && hit(x, x.mem_wr);
        mdh  = busy && (x.md || x.hilo);
        if (lu || bex || bmem || mdh) return 4'b0000;
        return 4'b1110;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d required %0d", nm, $time, act, exp);
        end
    endtask

    task automatic expo(input string nm, input logic [3:0] ea, input logic [3:0] eb);
        chk({nm, " A outs"}, int'({a_pc, a_ifid, a_ctrl, a_frz}), int'(ea));
        chk({nm, " B outs"}, int'({b_pc, b_ifid, b_ctrl, b_frz}), int'(eb));
    endtask

    // One clock: compare both instances with the model, then advance model state.
    task automatic step(input string nm);
        logic [3:0] e;
        logic [3:0] act;
        bit         busy;
        bit         frz;
        @(negedge Clk);
        frz = cur.mem_mr && !cur.mem_rdy;
        for (int d = 0; d < 2; d++) begin
            busy = (busy_left[d] > 0) && !rst;
            e    = model_out(cur, rst, busy, bid[d]);
            act  = (d == 0) ? {a_pc, a_ifid, a_ctrl, a_frz} : {b_pc, b_ifid, b_ctrl, b_frz};
            chk($sformatf("%s dut%0d outs", nm, d), int'(act), int'(e));
            chk($sformatf("%s dut%0d busy", nm, d), (d == 0) ? int'(a_busy) : int'(b_busy),
                int'(busy));
            chk($sformatf("%s dut%0d cnt", nm, d), (d == 0) ? int'(a_cnt) : int'(b_cnt),
                scnt[d]);
            if (rst) begin
                busy_left[d] = 0;
                scnt[d]      = 0;
            end else begin
                if (!e[2] && scnt[d] < cmax[d]) scnt[d]++;
                if (busy_left[d] > 0) begin
                    if (!frz) busy_left[d]--;
                end else if (cur.md && e == 4'b1110) begin
                    busy_left[d] = LAT - 1;
                end
            end
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cur = '0;
        cur.mem_rdy = 1'b1;
        step("reset");
        rst = 1'b0;
    endtask

    initial begin
        in_t idle;
        cmax[0] = 65535; cmax[1] = 3;
        bid[0]  = 1'b1;  bid[1]  = 1'b0;
        busy_left[0] = 0; busy_left[1] = 0;
        scnt[0] = 0; scnt[1] = 0;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        //        name        rs rt ur br md hl exrw exmr exwr mrw mmr mwr rdy     A        B
        vecs.push_back('{"loaduse",    mk(2, 4, 1, 0, 0, 0, 1, 1, 2, 0, 0, 0, 1), 4'b0000, 4'b0000});
        vecs.push_back('{"r0_nostall", mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1), 4'b1110, 4'b1110});
        vecs.push_back('{"itype_rt",   mk(1, 2, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0, 1), 4'b1110, 4'b1110});
        vecs.push_back('{"br_ex_alu",  mk(5, 6, 1, 1, 0, 0, 1, 0, 6, 0, 0, 0, 1), 4'b0000, 4'b1110});
        vecs.push_back('{"br_mem_ld",  mk(5, 6, 1, 1, 0, 0, 0, 0, 0, 1, 1, 6, 1), 4'b0000, 4'b1110});
        vecs.push_back('{"freeze",     mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 9, 0), 4'b0011, 4'b0011});
        vecs.push_back('{"frz_lu",     mk(2, 3, 1, 0, 0, 0, 1, 1, 2, 1, 1, 9, 0), 4'b0011, 4'b0011});
        vecs.push_back('{"loaduse_rt", mk(1, 7, 1, 0, 0, 0, 1, 1, 7, 0, 0, 0, 1), 4'b0000, 4'b0000});
        vecs.push_back('{"mem_fwd",    mk(3, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 3, 1), 4'b1110, 4'b1110});
        vecs.push_back('{"ex_alu_fwd", mk(4, 0, 1, 0, 0, 0, 1, 0, 4, 0, 0, 0, 1), 4'b1110, 4'b1110});

        do_reset();
        chk("reset cnt", int'(a_cnt), 0);

        foreach (vecs[i]) begin
            cur = vecs[i].in;
            #1;
            expo({"vec ", vecs[i].nm}, vecs[i].ea, vecs[i].eb);
            step(vecs[i].nm);
        end

        // Branch after load: two bubbles with branch-in-ID, one without.
        do_reset();
        cur = mk(5, 6, 1, 1, 0, 0, 1, 1, 5, 0, 0, 0, 1); #1;
        expo("brld c1", 4'b0000, 4'b0000); step("brld c1");
        cur = mk(5, 6, 1, 1, 0, 0, 0, 0, 0, 1, 1, 5, 1); #1;
        expo("brld c2", 4'b0000, 4'b1110); step("brld c2");
        cur = idle; #1;
        expo("brld c3", 4'b1110, 4'b1110); step("brld c3");

        // Freeze for 3 cycles with a pending load-use, then one bubble.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            cur = mk(2, 4, 1, 0, 0, 0, 1, 1, 2, 1, 1, 9, 0); #1;
            expo("frz hold", 4'b0011, 4'b0011); step("frz hold");
        end
        cur = mk(2, 4, 1, 0, 0, 0, 1, 1, 2, 1, 1, 9, 1); #1;
        expo("frz bubble", 4'b0000, 4'b0000); step("frz bubble");
        cur = mk(2, 4, 1, 0, 0, 0, 0, 0, 0, 1, 1, 2, 1); #1;
        expo("frz pass", 4'b1110, 4'b1110);
        chk("frz cnt", int'(a_cnt), 4);
        step("frz pass");

        // mult issued, mflo follows: busy and stalled for LAT-1 cycles.
        do_reset();
        cur = mk(1, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1); #1;
        expo("mul issue", 4'b1110, 4'b1110); step("mul issue");
        for (int k = 0; k < LAT - 1; k++) begin
            cur = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1); #1;
            expo("mflo stall", 4'b0000, 4'b0000);
            chk("mflo busy", int'(a_busy), 1);
            step("mflo stall");
        end
        #1;
        expo("mflo pass", 4'b1110, 4'b1110);
        chk("mflo idle", int'(a_busy), 0);
        step("mflo pass");

        // Reset during BUSY with Stall_Count=7; narrow counter saturates at 3.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            cur = mk(2, 4, 1, 0, 0, 0, 1, 1, 2, 0, 0, 0, 1);
            step("pre lu");
        end
        cur = mk(1, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        step("pre mul");
        cur = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        step("pre mflo");
        chk("cnt before rst", int'(a_cnt), 7);
        chk("sat cnt", int'(b_cnt), 3);
        chk("busy before rst", int'(a_busy), 1);
        rst = 1'b1; #1;
        expo("rst forced", 4'b1110, 4'b1110);
        chk("rst busy forced", int'(a_busy), 0);
        step("rst busy");
        rst = 1'b0; #1;
        expo("post rst", 4'b1110, 4'b1110);
        chk("post rst busy", int'(a_busy), 0);
        chk("post rst cnt", int'(a_cnt), 0);
        step("post rst");

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            cur.rs      = 5'($urandom_range(0, 3));
            cur.rt      = 5'($urandom_range(0, 3));
            cur.uses_rt = 1'($urandom_range(0, 1));
            cur.br      = 1'($urandom_range(0, 1));
            cur.md      = ($urandom_range(0, 3) == 0);
            cur.hilo    = ($urandom_range(0, 3) == 0);
            cur.ex_rw   = 1'($urandom_range(0, 1));
            cur.ex_mr   = 1'($urandom_range(0, 1));
            cur.ex_wr   = 5'($urandom_range(0, 3));
            cur.mem_rw  = 1'($urandom_range(0, 1));
            cur.mem_mr  = 1'($urandom_range(0, 1));
            cur.mem_wr  = 5'($urandom_range(0, 3));
            cur.mem_rdy = ($urandom_range(0, 3) != 0);
            rst         = ($urandom_range(0, 60) == 0);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
